// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM handshake types.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/ram_master.sv
// RAM initiator: arbitrates instruction and data clients onto a variable-latency RAM
// and reports a sticky error on RAM error or drive timeout.
module ram_master
    import cpu_types_pkg::*;
#(
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] BADWORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        err
);
    // state | meaning
    // IDLE  | no transaction, arbitrate between clients
    // IACC  | driving captured instruction read
    // DACC  | driving captured data read or write
    // RESP  | one-cycle completion, served client's wait low, enables off
    typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

    localparam logic [15:0] TO16 = 16'(TIMEOUT);

    state_t      state, state_nx;
    logic        last, last_nx;       // 1: data was served last
    logic        served, served_nx;   // 1: current transaction belongs to data
    logic        wr, wr_nx;
    logic [15:0] cnt, cnt_nx;
    logic [31:0] addr_nx, store_nx, iload_nx, dload_nx;
    logic        err_nx;
    logic        dreq;

    assign dreq = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            last     <= 1'b0;
            served   <= 1'b0;
            wr       <= 1'b0;
            cnt      <= '0;
            ramaddr  <= '0;
            ramstore <= '0;
            iload    <= '0;
            dload    <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            served   <= served_nx;
            wr       <= wr_nx;
            cnt      <= cnt_nx;
            ramaddr  <= addr_nx;
            ramstore <= store_nx;
            iload    <= iload_nx;
            dload    <= dload_nx;
            err      <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        last_nx   = last;
        served_nx = served;
        wr_nx     = wr;
        cnt_nx    = cnt;
        addr_nx   = ramaddr;
        store_nx  = ramstore;
        iload_nx  = iload;
        dload_nx  = dload;
        err_nx    = err;
        case (state)
            IDLE: begin
                // data wins contention unless it was the last one served
                if (dreq && (!iREN || !last)) begin
                    state_nx  = DACC;
                    served_nx = 1'b1;
                    wr_nx     = dWEN;
                    addr_nx   = daddr;
                    store_nx  = dstore;
                    cnt_nx    = 16'd1;
                end else if (iREN) begin
                    state_nx  = IACC;
                    served_nx = 1'b0;
                    wr_nx     = 1'b0;
                    addr_nx   = iaddr;
                    cnt_nx    = 16'd1;
                end
            end
            IACC, DACC: begin
                if (ramstate == ACCESS) begin
                    if (!wr) begin
                        if (served) dload_nx = ramload;
                        else        iload_nx = ramload;
                    end
                    last_nx  = served;
                    state_nx = RESP;
                end else if (ramstate == ERROR || cnt >= TO16) begin
                    if (!wr) begin
                        if (served) dload_nx = BADWORD;
                        else        iload_nx = BADWORD;
                    end
                    err_nx   = 1'b1;
                    state_nx = RESP;
                end else if (cnt != TO16) begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ramREN = (state == IACC) || (state == DACC && !wr);
    assign ramWEN = (state == DACC) && wr;
    assign iwait  = iREN & ~(state == RESP && !served);
    assign dwait  = dreq & ~(state == RESP && served);
endmodule
